// File: rtl/hls_core_chn_o_rsci_fifo.sv
// DEPTH-entry output-channel buffer between an HLS core and a valid/ready consumer; a push shows on z/lz
// the next cycle (no bypass); wen_comp drops while all DEPTH entries are held, and z/lz hold while vz is low.
module hls_core_chn_o_rsci_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [WIDTH-1:0] chn_o_rsci_d,
    input  logic             chn_o_rsci_iswt0,
    input  logic             chn_o_rsci_flush,
    output logic             chn_o_rsci_wen_comp,
    output logic             chn_o_rsci_bawt,
    output logic [CNT_W-1:0] chn_o_rsci_count,
    output logic [WIDTH-1:0] chn_o_rsc_z,
    output logic             chn_o_rsc_lz,
    input  logic             chn_o_rsc_vz
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             bawt;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Flags come from the count register alone, so no input reaches an output combinationally.
    assign chn_o_rsci_wen_comp = (count != FULL_CNT);
    assign chn_o_rsc_lz        = (count != '0);
    assign chn_o_rsci_count    = count;
    assign chn_o_rsci_bawt     = bawt;
    assign chn_o_rsc_z         = chn_o_rsc_lz ? mem[rd_ptr] : '0;

    assign push = chn_o_rsci_iswt0 & chn_o_rsci_wen_comp;
    assign pop  = chn_o_rsc_lz & chn_o_rsc_vz;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bawt   <= 1'b0;
        end else if (chn_o_rsci_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bawt   <= 1'b0;
        end else begin
            bawt <= push;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; z is masked while empty instead.
    always_ff @(posedge nvdla_core_clk) begin
        if (push && !chn_o_rsci_flush) mem[wr_ptr] <= chn_o_rsci_d;
    end
endmodule
